// File: rtl/mse_loss_stream.sv
// Streaming MSE reduction: four-stage squared-difference pipeline that feeds a batch accumulator, emitting floor(sum/NUM_ELEMS) once per batch.
// Optional MSE_LOSS_SATURATE_EN clamps an over-range mean to all ones instead of truncating it.
module mse_loss_stream #(
  parameter int DATA_W    = 16,
  parameter int LANES     = 4,
  parameter int NUM_ELEMS = 4096,
  parameter int OUT_W     = 32,
  parameter int ACC_W     = 2*DATA_W + $clog2(NUM_ELEMS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES*DATA_W-1:0] pred_data,
  input  logic [LANES*DATA_W-1:0] tgt_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        out_data,
  output logic                    busy
);

  localparam int LOG_N  = $clog2(NUM_ELEMS);
  localparam int BEATS  = NUM_ELEMS / LANES;
  localparam int CNT_W  = $clog2(BEATS + 1);
  localparam int DIFF_W = DATA_W + 1;
  localparam int SQ_W   = 2 * DATA_W;
  localparam int SUM_W  = SQ_W + $clog2(LANES);
  localparam logic [ACC_W-1:0] OUT_MAX = ACC_W'({OUT_W{1'b1}});

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_DRAIN, ST_OUTPUT} state_e;

  state_e                    state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [ACC_W-1:0]          acc_q;
  logic                      in_ready_q, busy_q, out_valid_q;
  logic [OUT_W-1:0]          out_data_q;

  logic                      s1_vld_q, s2_vld_q, s3_vld_q;
  logic signed [DIFF_W-1:0]  diff_q [LANES];
  logic        [SQ_W-1:0]    sq_q   [LANES];
  logic        [SUM_W-1:0]   sum_q;

  logic signed [DIFF_W-1:0]  diff_d [LANES];
  logic        [DATA_W-1:0]  mag_d  [LANES];
  logic        [SQ_W-1:0]    sq_d   [LANES];
  logic        [SUM_W-1:0]   sum_d;
  logic        [OUT_W-1:0]   res_d;
  logic                      accept;

  assign accept    = in_valid && in_ready_q;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

  // |diff| <= 2^DATA_W-1, so the magnitude fits DATA_W bits and its square fits SQ_W
  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      diff_d[i] = {pred_data[i*DATA_W + DATA_W - 1], pred_data[i*DATA_W +: DATA_W]}
                - {tgt_data[i*DATA_W + DATA_W - 1],  tgt_data[i*DATA_W +: DATA_W]};
      mag_d[i]  = diff_q[i][DIFF_W-1] ? DATA_W'(-diff_q[i]) : DATA_W'(diff_q[i]);
      sq_d[i]   = SQ_W'(mag_d[i]) * SQ_W'(mag_d[i]);
    end
  end

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < LANES; i++) begin
      sum_d = sum_d + SUM_W'(sq_q[i]);
    end
  end

  always_comb begin
`ifdef MSE_LOSS_SATURATE_EN
    res_d = ((acc_q >> LOG_N) > OUT_MAX) ? {OUT_W{1'b1}} : OUT_W'(acc_q >> LOG_N);
`else
    res_d = OUT_W'(acc_q >> LOG_N);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      sum_q    <= '0;
      for (int i = 0; i < LANES; i++) begin
        diff_q[i] <= '0;
        sq_q[i]   <= '0;
      end
    end else begin
      s1_vld_q <= accept;
      s2_vld_q <= s1_vld_q;
      s3_vld_q <= s2_vld_q;
      for (int i = 0; i < LANES; i++) begin
        if (accept)   diff_q[i] <= diff_d[i];
        if (s1_vld_q) sq_q[i]   <= sq_d[i];
      end
      if (s2_vld_q) sum_q <= sum_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (s3_vld_q) acc_q <= acc_q + ACC_W'(sum_q);
      case (state_q)
        ST_IDLE: begin
          in_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (accept) begin
            busy_q <= 1'b1;
            cnt_q  <= CNT_W'(1);
            if (BEATS == 1) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end else begin
              state_q <= ST_ACCUM;
            end
          end
        end
        ST_ACCUM: begin
          if (accept) begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BEATS - 1)) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        // pipeline empty means the final lane sum already landed in acc_q
        ST_DRAIN: begin
          if (!s1_vld_q && !s2_vld_q && !s3_vld_q) begin
            state_q     <= ST_OUTPUT;
            out_valid_q <= 1'b1;
            out_data_q  <= res_d;
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mse_loss_stream.sv
// Scoreboard bench for mse_loss_stream (LANES=4, NUM_ELEMS=8, OUT_W=24); expected means are hand-computed.
module tb_mse_loss_stream;

  localparam int DW = 16;
  localparam int LN = 4;
  localparam int NE = 8;
  localparam int OW = 24;

`ifdef MSE_LOSS_SATURATE_EN
  localparam logic [OW-1:0] EXT_EXP = 24'hFFFFFF;
`else
  localparam logic [OW-1:0] EXT_EXP = 24'hFE0001;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, out_valid, out_ready, busy;
  logic [LN*DW-1:0]  pred_data, tgt_data;
  logic [OW-1:0]     out_data;

  int total = 0;
  int bad   = 0;
  logic [OW-1:0] exp_q[$];

  always #5 clk = ~clk;

  mse_loss_stream #(.DATA_W(DW), .LANES(LN), .NUM_ELEMS(NE), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .pred_data(pred_data), .tgt_data(tgt_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  function automatic logic [63:0] pack4(input int a, input int b, input int c, input int d);
    return {d[15:0], c[15:0], b[15:0], a[15:0]};
  endfunction

  task automatic beat(input logic [63:0] p, input logic [63:0] t);
    int n;
    @(negedge clk);
    pred_data = p;
    tgt_data  = t;
    in_valid  = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // called right after the last beat's accept edge
  task automatic check_latency(input string tag);
    repeat (4) @(negedge clk);
    chk({tag, "_vld_before_t4"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_vld_at_t4"}, 32'(out_valid), 32'd1);
    chk({tag, "_rdy_in_output"}, 32'(in_ready), 32'd0);
  endtask

  always @(negedge clk) begin : monitor
    logic [OW-1:0] e;
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected: got 0x%0h expected no result", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", 32'(out_data), 32'(e));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    pred_data = '0; tgt_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready",  32'(in_ready),  32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_busy",     32'(busy),     32'd0);

    // basic mean with 10 cycles of backpressure and in_valid held during OUTPUT
    exp_q.push_back(24'd4);
    beat(pack4(3, 3, 3, 3), pack4(1, 1, 1, 1));
    beat(pack4(3, 3, 3, 3), pack4(1, 1, 1, 1));
    check_latency("basic");
    chk("basic_busy", 32'(busy), 32'd1);
    in_valid = 1'b1; pred_data = pack4(100, 100, 100, 100); tgt_data = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_vld",  32'(out_valid), 32'd1);
      chk("hold_data", 32'(out_data),  32'd4);
      chk("hold_rdy",  32'(in_ready),  32'd0);
    end
    @(posedge clk);
    #1 in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("release_in_ready",  32'(in_ready),  32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);

    // sign handling; out_ready already high gives a single-cycle result pulse
    exp_q.push_back(24'd16);
    beat(pack4(5, -5, 0, -7), pack4(-3, 3, 0, -7));
    beat(pack4(0, 0, 0, 0), pack4(0, 0, 0, 0));
    check_latency("sign");
    @(negedge clk);
    chk("sign_pulse_one_cycle", 32'(out_valid), 32'd0);
    chk("sign_in_ready_back",   32'(in_ready),  32'd1);

    // gappy input: in_valid 1,0,0,1
    exp_q.push_back(24'd4);
    beat(pack4(3, 3, 3, 3), pack4(1, 1, 1, 1));
    repeat (2) @(posedge clk);
    beat(pack4(3, 3, 3, 3), pack4(1, 1, 1, 1));
    check_latency("gappy");

    // reset after the first of two beats discards the partial batch
    beat(pack4(9, 9, 9, 9), pack4(0, 0, 0, 0));
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready",  32'(in_ready),  32'd0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data",  32'(out_data),  32'd0);
    chk("mid_rst_busy",      32'(busy),      32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(24'd1);
    beat(pack4(-3, 1, 101, -32767), pack4(-4, 0, 100, -32768));
    beat(pack4(-3, 1, 101, -32767), pack4(-4, 0, 100, -32768));
    check_latency("post_abort");

    // extreme difference: mean 0xFFFE0001 exceeds 24 bits
    exp_q.push_back(EXT_EXP);
    beat(pack4(-32768, -32768, -32768, -32768), pack4(32767, 32767, 32767, 32767));
    beat(pack4(-32768, -32768, -32768, -32768), pack4(32767, 32767, 32767, 32767));
    check_latency("extreme");

    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
